// File: rtl/stream_pkg.sv
// Shared definitions for the result-stream path: default sizes, word type and serialiser states.
package stream_pkg;

    localparam int unsigned STREAM_DATA_WIDTH = 32;
    localparam int unsigned STREAM_FIFO_DEPTH = 16;
    localparam logic [7:0]  STREAM_EMPTY_BYTE = 8'h00;

    typedef logic [STREAM_DATA_WIDTH-1:0] stream_word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        SENDING = 2'd2
    } ser_state_t;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Circular FIFO pointer pair with wrap bit, full/empty flags and registered occupancy count.
module sync_fifo_ptr #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] wr_ptr,
    output logic [$clog2(DEPTH):0] rd_ptr,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_nxt_c,
    output logic                   full_c,
    output logic                   empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_nxt_c;
    logic [PW-1:0] rd_nxt_c;

    // Push/pop are self-guarded so a caller can never corrupt the pointers.
    always_comb begin
        full_c      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty_c     = (wr_ptr == rd_ptr);
        wr_nxt_c    = wr_ptr + PW'(push && !full_c);
        rd_nxt_c    = rd_ptr + PW'(pop && !empty_c);
        count_nxt_c = wr_nxt_c - rd_nxt_c;
        if (clear) begin
            wr_nxt_c    = '0;
            rd_nxt_c    = '0;
            count_nxt_c = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_nxt_c;
            rd_ptr <= rd_nxt_c;
            count  <= count_nxt_c;
        end
    end

endmodule

// File: rtl/stream_byte_fifo.sv
// Word FIFO between the core result stream and the SPI transmitter, emitting bytes MSB-first on request.
module stream_byte_fifo
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = STREAM_DATA_WIDTH,
    parameter int unsigned DEPTH      = STREAM_FIFO_DEPTH,
    parameter logic [7:0]  EMPTY_BYTE = STREAM_EMPTY_BYTE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   byte_req,
    output logic [7:0]             tx_byte,
    output logic                   tx_byte_valid,
    output logic [$clog2(DEPTH):0] word_count,
    output logic                   overflow,
    output logic                   underrun
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned BPW = DATA_WIDTH / 8;
    localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BIW-1:0] LAST_IDX = BIW'(BPW - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         count_nxt_c;
    logic                  full_c;
    logic                  empty_c;
    logic                  push_c;
    logic                  serve_c;
    logic                  pop_c;
    logic                  last_byte_c;
    logic [DATA_WIDTH-1:0] head_c;
    logic [7:0]            sel_byte_c;
    logic [BIW-1:0]        byte_idx;
    logic [BIW-1:0]        byte_idx_nxt;
    ser_state_t            state;
    ser_state_t            state_nxt;

    // Flush blocks any push or request issued in the same cycle.
    assign push_c      = in_valid && !full_c && !flush;
    assign serve_c     = byte_req && !empty_c && !flush;
    assign last_byte_c = (byte_idx == LAST_IDX);
    assign pop_c       = serve_c && last_byte_c;
    assign in_ready    = !full_c;

    assign head_c     = mem[rd_ptr[AW-1:0]];
    assign sel_byte_c = 8'(head_c >> (8 * (BPW - 1 - 32'(byte_idx))));

    sync_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (flush),
        .push        (push_c),
        .pop         (pop_c),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (word_count),
        .count_nxt_c (count_nxt_c),
        .full_c      (full_c),
        .empty_c     (empty_c)
    );

    // Storage is not reset; only words behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_idx <= '0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_idx_nxt;
        end
    end

    // Serialiser FSM: tracks head presence and position within the head word.
    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        if (flush) begin
            state_nxt    = IDLE;
            byte_idx_nxt = '0;
        end else begin
            if (serve_c) begin
                byte_idx_nxt = last_byte_c ? '0 : byte_idx + BIW'(1);
            end
            case (state)
                IDLE: begin
                    if (push_c) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (pop_c) begin
                        state_nxt = (count_nxt_c == '0) ? IDLE : HOLD;
                    end else if (serve_c) begin
                        state_nxt = SENDING;
                    end
                end
                SENDING: begin
                    if (pop_c) begin
                        state_nxt = (count_nxt_c == '0) ? IDLE : HOLD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_byte       <= 8'h00;
            tx_byte_valid <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else if (flush) begin
            tx_byte_valid <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            tx_byte_valid <= byte_req;
            if (byte_req) begin
                tx_byte <= empty_c ? EMPTY_BYTE : sel_byte_c;
            end
            if (byte_req && empty_c) begin
                underrun <= 1'b1;
            end
            if (in_valid && full_c) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
